// File: rtl/bytebeat_scheduler_if.sv
// Core-side handshake bundle: per-channel parameter valid/ready plus the PCM return path.
interface bytebeat_scheduler_if;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic [3:0] c_out;
  logic [3:0] d_out;
  logic       a_vld;
  logic       b_vld;
  logic       c_vld;
  logic       d_vld;
  logic       a_rdy;
  logic       b_rdy;
  logic       c_rdy;
  logic       d_rdy;
  logic [7:0] pcm_in;
  logic       pcm_in_vld;
  logic       pcm_in_rdy;

  // Scheduler side
  modport master (
    output a_out, b_out, c_out, d_out,
    output a_vld, b_vld, c_vld, d_vld,
    input  a_rdy, b_rdy, c_rdy, d_rdy,
    input  pcm_in, pcm_in_vld,
    output pcm_in_rdy
  );

  // Core side
  modport slave (
    input  a_out, b_out, c_out, d_out,
    input  a_vld, b_vld, c_vld, d_vld,
    output a_rdy, b_rdy, c_rdy, d_rdy,
    output pcm_in, pcm_in_vld,
    input  pcm_in_rdy
  );
endinterface

// File: rtl/bytebeat_scheduler.sv
// Sample-rate scheduler for the bytebeat core: paces samples at period+1 cycles, issues one
// {a,b,c,d} parameter set per sample, holds the returned PCM and flags missed deadlines.
module bytebeat_scheduler #(
  parameter int unsigned PERIOD_W = 12,
  parameter int unsigned UR_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [15:0]         param_in,
  input  logic                param_load,
  bytebeat_scheduler_if.master core,
  output logic [7:0]          pcm_out,
  output logic                pcm_strobe,
  output logic                running,
  output logic                underrun,
  output logic [UR_W-1:0]     underrun_cnt,
  input  logic                underrun_clr
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e              state_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic [15:0]         active_q;
  logic [15:0]         shadow_q;
  logic                pending_q;
  logic [7:0]          buf_q;
  logic [3:0]          vld_q;
  logic                pcm_in_rdy_q;

  logic       tick;
  logic       hold_tick;
  logic       ur_event;
  logic       commit;
  logic [3:0] rdy;
  logic [3:0] vld_rem;

  // Tick decode and channel handshake bookkeeping
  always_comb begin
    tick      = (state_q != StIdle) && (cnt_q == '0);
    hold_tick = tick && (state_q == StHold);
    ur_event  = tick && ((state_q == StIssue) || (state_q == StWait));
    commit    = hold_tick && pending_q;
    rdy       = {core.d_rdy, core.c_rdy, core.b_rdy, core.a_rdy};
    // Channels still owed a handshake after this cycle
    vld_rem   = vld_q & ~rdy;
  end

  assign core.a_out      = active_q[3:0];
  assign core.b_out      = active_q[7:4];
  assign core.c_out      = active_q[11:8];
  assign core.d_out      = active_q[15:12];
  assign core.a_vld      = vld_q[0];
  assign core.b_vld      = vld_q[1];
  assign core.c_vld      = vld_q[2];
  assign core.d_vld      = vld_q[3];
  assign core.pcm_in_rdy = pcm_in_rdy_q;

  // Shadow/active parameter registers; a load at a commit tick defers to the next tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (param_load) shadow_q <= param_in;
      if (commit) active_q <= shadow_q;
      pending_q <= param_load | (pending_q & ~commit);
    end
  end

  // Sticky underrun flag and saturating miss counter; an event beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (ur_event) begin
      underrun <= 1'b1;
      if (underrun_clr) begin
        underrun_cnt <= UR_W'(1);
      end else if (!(&underrun_cnt)) begin
        underrun_cnt <= underrun_cnt + 1'b1;
      end
    end else if (underrun_clr) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end
  end

  // Main FSM with sample counter and registered core/host outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      vld_q        <= '0;
      pcm_in_rdy_q <= 1'b0;
      buf_q        <= '0;
      pcm_out      <= '0;
      pcm_strobe   <= 1'b0;
      running      <= 1'b0;
    end else begin
      pcm_strobe <= 1'b0;
      if (state_q != StIdle) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // Missed deadline: restart the period but let the transaction in flight continue
      if (ur_event) begin
        pcm_strobe <= 1'b1;
        cnt_q      <= period;
      end
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            cnt_q   <= period;
            state_q <= StIssue;
            vld_q   <= 4'hf;
            running <= 1'b1;
          end
        end
        StIssue: begin
          vld_q <= vld_rem;
          if (vld_rem == '0) begin
            state_q      <= StWait;
            pcm_in_rdy_q <= 1'b1;
          end
        end
        StWait: begin
          if (core.pcm_in_vld) begin
            buf_q        <= core.pcm_in;
            state_q      <= StHold;
            pcm_in_rdy_q <= 1'b0;
          end
        end
        StHold: begin
          if (hold_tick) begin
            pcm_out    <= buf_q;
            pcm_strobe <= 1'b1;
            if (enable) begin
              cnt_q   <= period;
              state_q <= StIssue;
              vld_q   <= 4'hf;
            end else begin
              cnt_q   <= '0;
              state_q <= StIdle;
              running <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bytebeat_scheduler.sv
// Directed bench for bytebeat_scheduler: pacing, param shadowing, staggered handshakes,
// underruns, counter saturation, reset and disable.
module tb_bytebeat_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] period;
  logic [15:0] param_in;
  logic        param_load;
  logic [7:0]  pcm_out;
  logic        pcm_strobe;
  logic        running;
  logic        underrun;
  logic [7:0]  underrun_cnt;
  logic        underrun_clr;

  int n_pass  = 0;
  int n_total = 0;

  bytebeat_scheduler_if bus ();

  bytebeat_scheduler #(
    .PERIOD_W (12),
    .UR_W     (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .period       (period),
    .param_in     (param_in),
    .param_load   (param_load),
    .core         (bus),
    .pcm_out      (pcm_out),
    .pcm_strobe   (pcm_strobe),
    .running      (running),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdy(input logic [3:0] r);
    {bus.d_rdy, bus.c_rdy, bus.b_rdy, bus.a_rdy} = r;
  endtask

  function automatic logic [15:0] params();
    return {bus.d_out, bus.c_out, bus.b_out, bus.a_out};
  endfunction

  function automatic logic [3:0] vlds();
    return {bus.d_vld, bus.c_vld, bus.b_vld, bus.a_vld};
  endfunction

  // Cycles until the next strobe, bounded
  task automatic wait_strobe(input string tag, input int exp_cyc);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!pcm_strobe && k < 64);
    check(tag, k, exp_cyc);
  endtask

  initial begin
    int ns;
    reset        = 1'b1;
    enable       = 1'b0;
    period       = '0;
    param_in     = '0;
    param_load   = 1'b0;
    underrun_clr = 1'b0;
    bus.pcm_in     = '0;
    bus.pcm_in_vld = 1'b0;
    set_rdy(4'h0);
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_vld", vlds(), 4'h0);
    check("rst_pcm_in_rdy", bus.pcm_in_rdy, 1'b0);
    check("rst_pcm_out", pcm_out, 8'h00);
    check("rst_strobe", pcm_strobe, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_ur_cnt", underrun_cnt, 8'd0);

    // Zero-wait core, period 3: first strobe at E+5, then every 4 cycles
    period         = 12'd3;
    set_rdy(4'hf);
    bus.pcm_in     = 8'h5a;
    bus.pcm_in_vld = 1'b1;
    enable         = 1'b1;
    step();
    check("en_running", running, 1'b1);
    check("en_vld_all", vlds(), 4'hf);
    wait_strobe("first_strobe", 4);
    check("first_pcm", pcm_out, 8'h5a);
    step();
    check("strobe_one_cycle", pcm_strobe, 1'b0);
    wait_strobe("period_a", 3);
    wait_strobe("period_b", 4);
    check("pace_pcm", pcm_out, 8'h5a);
    check("pace_no_underrun", underrun, 1'b0);

    // Mid-sample load applies at the next tick
    check("params_old", params(), 16'h0000);
    param_in   = 16'h4321;
    param_load = 1'b1;
    step();
    param_load = 1'b0;
    check("params_still_old", params(), 16'h0000);
    wait_strobe("params_tick", 3);
    check("params_new", params(), 16'h4321);
    check("params_new_vld", vlds(), 4'hf);

    // Pending 8765 commits at the tick; CBA9 loaded at that tick waits one more
    param_in   = 16'h8765;
    param_load = 1'b1;
    step();
    param_load = 1'b0;
    step();
    step();
    param_in   = 16'hcba9;
    param_load = 1'b1;
    step();
    param_load = 1'b0;
    check("coinc_strobe", pcm_strobe, 1'b1);
    check("params_coinc", params(), 16'h8765);
    wait_strobe("coinc_next", 4);
    check("params_deferred", params(), 16'hcba9);

    // Staggered readies with a long period
    step();
    step();
    step();
    set_rdy(4'h0);
    period = 12'd9;
    step();
    check("stag_strobe", pcm_strobe, 1'b1);
    check("stag_c1_vld", vlds(), 4'hf);
    set_rdy(4'b0001);
    step();
    check("stag_c2_vld", vlds(), 4'b1110);
    set_rdy(4'b0110);
    step();
    check("stag_c3_vld", vlds(), 4'b1000);
    check("stag_c3_data", params(), 16'hcba9);
    set_rdy(4'h0);
    step();
    check("stag_c4_vld", vlds(), 4'b1000);
    check("stag_c4_data", params(), 16'hcba9);
    set_rdy(4'b1000);
    step();
    check("stag_done_vld", vlds(), 4'h0);
    check("stag_wait_rdy", bus.pcm_in_rdy, 1'b1);
    set_rdy(4'hf);
    period = 12'd3;
    wait_strobe("stag_tick", 6);
    check("stag_no_underrun", underrun, 1'b0);

    // Stalled sample: two underrun ticks, then the late sample
    bus.pcm_in_vld = 1'b0;
    bus.pcm_in     = 8'h33;
    wait_strobe("ur_tick1", 4);
    check("ur1_pcm", pcm_out, 8'h5a);
    check("ur1_flag", underrun, 1'b1);
    check("ur1_cnt", underrun_cnt, 8'd1);
    wait_strobe("ur_tick2", 4);
    check("ur2_pcm", pcm_out, 8'h5a);
    check("ur2_cnt", underrun_cnt, 8'd2);
    step();
    step();
    bus.pcm_in_vld = 1'b1;
    wait_strobe("late_tick", 2);
    check("late_pcm", pcm_out, 8'h33);
    check("late_cnt", underrun_cnt, 8'd2);

    // Clear coincident with an underrun tick: event wins
    bus.pcm_in_vld = 1'b0;
    step();
    step();
    step();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("clr_coinc_strobe", pcm_strobe, 1'b1);
    check("clr_coinc_flag", underrun, 1'b1);
    check("clr_coinc_cnt", underrun_cnt, 8'd1);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("clr_flag", underrun, 1'b0);
    check("clr_cnt", underrun_cnt, 8'd0);

    // Period 0 in WAIT underruns every cycle; counter saturates
    period = 12'd0;
    repeat (310) step();
    check("sat_cnt", underrun_cnt, 8'hff);
    check("sat_flag", underrun, 1'b1);
    check("sat_pcm", pcm_out, 8'h33);

    // Asynchronous reset mid-WAIT
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check("arst_running", running, 1'b0);
    check("arst_pcm_in_rdy", bus.pcm_in_rdy, 1'b0);
    check("arst_pcm_out", pcm_out, 8'h00);
    check("arst_underrun", underrun, 1'b0);
    check("arst_ur_cnt", underrun_cnt, 8'd0);
    check("arst_vld", vlds(), 4'h0);
    step();
    reset = 1'b0;
    step();
    check("idle_after_reset", running, 1'b0);

    // Re-enable, then disable at the HOLD tick
    period         = 12'd3;
    bus.pcm_in     = 8'h77;
    bus.pcm_in_vld = 1'b1;
    enable         = 1'b1;
    wait_strobe("reen_strobe", 5);
    check("reen_pcm", pcm_out, 8'h77);
    enable = 1'b0;
    wait_strobe("dis_strobe", 4);
    check("dis_running", running, 1'b0);
    check("dis_pcm", pcm_out, 8'h77);
    ns = 0;
    repeat (10) begin
      step();
      if (pcm_strobe) ns++;
    end
    check("dis_no_strobes", ns, 0);
    check("dis_still_idle", running, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bytebeat_scheduler.md
# bytebeat_scheduler

Sample-rate scheduler and parameter controller for the bytebeat generator core. It paces the core at a programmable sample period and issues one parameter set {a,b,c,d} per sample over the core's per-channel valid/ready inputs. It collects each PCM result and presents it on a held output with a one-cycle strobe at every sample tick. It sits between the top-level pin logic and the core, and it reports underruns when the core misses a deadline.

## Interface
- `PERIOD_W`, default 12: width of the sample-period input and the internal down-counter.
- `UR_W`, default 8: width of the saturating underrun counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run request; level-sensitive.
- `period`  in  PERIOD_W  clock cycles per sample minus one; sampled only on counter reload.
- `param_in`  in  16  staged parameters {d[15:12], c[11:8], b[7:4], a[3:0]}.
- `param_load`  in  1  one-cycle pulse; captures `param_in` into the shadow register.
- `a_out`, `b_out`, `c_out`, `d_out`  out  4 each  active parameters to the core.
- `a_vld`, `b_vld`, `c_vld`, `d_vld`  out  1 each  per-channel valid to the core.
- `a_rdy`, `b_rdy`, `c_rdy`, `d_rdy`  in  1 each  per-channel ready from the core.
- `pcm_in`  in  8  sample from the core.
- `pcm_in_vld`  in  1  core sample valid.
- `pcm_in_rdy`  out  1  scheduler ready for a sample.
- `pcm_out`  out  8  held audio sample.
- `pcm_strobe`  out  1  one-cycle pulse when `pcm_out` updates.
- `running`  out  1  high when the state is not IDLE.
- `underrun`  out  1  sticky deadline-miss flag.
- `underrun_cnt`  out  UR_W  saturating count of missed ticks.
- `underrun_clr`  in  1  clears `underrun` and `underrun_cnt`.

## Operation
- Reset state: state IDLE; counter 0; active and shadow params 0; pending 0; sample buffer 0.
- Reset values of outputs: all `*_vld` = 0; `pcm_in_rdy` = 0; `pcm_out` = 0x00; `pcm_strobe` = 0; `running` = 0; `underrun` = 0; `underrun_cnt` = 0.
- Shadow register:
  - `param_load` writes the shadow and sets pending.
  - At a tick with pending = 1, active ← shadow and pending is cleared.
  - A `param_load` in the same cycle as a tick still writes the shadow, but the commit uses the pre-load shadow and pending stays set. The new value therefore applies at the following tick.
- FSM:
  - IDLE: the counter holds. When `enable` = 1: counter ← `period`, go to ISSUE.
  - ISSUE: every channel not yet accepted drives vld = 1 with its active nibble. A channel's vld falls the cycle after its vld&rdy handshake. Data stays stable while vld is high. When all four have handshaken, go to WAIT.
  - WAIT: `pcm_in_rdy` = 1. When `pcm_in_vld` = 1: buffer ← `pcm_in`, go to HOLD.
  - HOLD: wait for a tick.
- Counter: decrements every cycle outside IDLE. A tick is any cycle outside IDLE in which the counter = 0.
- Tick in HOLD:
  - `pcm_out` ← buffer and `pcm_strobe` pulses.
  - Commit the shadow if pending.
  - If `enable` = 1: counter ← `period`, go to ISSUE. Otherwise go to IDLE.
- Tick in ISSUE or WAIT (underrun):
  - `pcm_out` is unchanged, but `pcm_strobe` still pulses.
  - Set `underrun`; `underrun_cnt` increments and saturates at all-ones.
  - Counter ← `period`. The state is unchanged and the in-flight transaction continues.
  - Param commit is skipped at an underrun tick.
  - `enable` is not examined at an underrun tick.
- `underrun_clr` together with an underrun event: the event wins, giving `underrun` = 1 and `underrun_cnt` = 1.
- `enable` falling outside a HOLD tick has no effect until the next HOLD tick. A handshake is never abandoned.

## Timing
- All outputs are registered.
- `pcm_strobe` is high for exactly one cycle, the cycle after the tick edge.
- The sample period is `period`+1 cycles.
- With a zero-wait core (rdy tied high, sample valid on the first WAIT cycle), `period` = 2 is the minimum underrun-free setting. `period` = 0 or 1 always underruns.
- Enable latency: `enable` rises in cycle E (IDLE). Then ISSUE at E+1, the first tick at E+1+`period`, and `pcm_strobe`/`pcm_out` update at E+2+`period`.
- `running` rises at E+1 and falls the cycle after the disabling HOLD tick.
- Asynchronous reset forces the reset values immediately in any state, including mid-handshake.

## Test plan
- Enable with `period` = 3 and a zero-wait core returning 0x5A → first strobe at E+5, then a strobe every 4 cycles with `pcm_out` = 0x5A; `underrun` stays 0.
- `param_load` of 0x4321 mid-sample → the current ISSUE still shows the old a–d. The next ISSUE after the tick shows a=1, b=2, c=3, d=4. A load coincident with a tick applies one tick later.
- Staggered readies (`a_rdy` in ISSUE cycle 1, `b_rdy`/`c_rdy` in cycle 2, `d_rdy` in cycle 4) → each vld drops individually after its handshake, data is stable while vld is high, and WAIT is entered after `d` accepts.
- `period` = 3 with `pcm_in_vld` stalled 10 cycles → 2 underrun ticks: strobes with `pcm_out` unchanged, `underrun` = 1, `underrun_cnt` = 2. The late sample is output at the next tick.
- `underrun_clr` coincident with an underrun tick → `underrun` = 1, `underrun_cnt` = 1. Forcing 300 underruns → `underrun_cnt` = 255.
- `reset` asserted mid-WAIT, then `enable` low at a HOLD tick → outputs 0 and IDLE immediately after reset. The disabling tick strobes once, then `running` = 0 and no further strobes.
